// File: rtl/apb_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave
// Purpose  : APB completer backed by a DEPTH-word register file, with a
//            programmable number of wait states before PREADY.
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave #(
   parameter int size        = 32,
   parameter int addr        = 8,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk_APB,
   input  logic              rst,
   input  logic              PSEL,
   input  logic              PEN,
   input  logic              PW,
   input  logic [addr-1:0]   PADDR,
   input  logic [size-1:0]   PWDATA,
   output logic              PREADY,
   output logic [size-1:0]   PRDATA,
   output logic              PSLVERR,
   output logic [1:0]        state
);

   localparam int              c_iw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [addr:0]   c_depth = (addr+1)'(DEPTH);
   localparam logic [3:0]      c_ws    = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2,
      S_ILL  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        r_cnt;
   logic [addr-1:0]   r_addr;
   logic [size-1:0]   r_wdata;
   logic              r_dir;
   logic [size-1:0]   r_mem [DEPTH];
   logic              r_pready;
   logic [size-1:0]   r_prdata;
   logic              r_pslverr;

   logic              w_access;
   logic [addr-1:0]   w_xfer_addr;
   logic              w_xfer_dir;
   logic              w_xfer_in_range;
   logic              w_lat_in_range;
   logic              w_commit;
   logic              w_enter_resp;

   assign w_access = PSEL & PEN;

   // With zero wait states the response is formed on the same edge that
   // latches the request, so the live bus is used in IDLE.
   assign w_xfer_addr     = (r_state == S_IDLE) ? PADDR : r_addr;
   assign w_xfer_dir      = (r_state == S_IDLE) ? PW    : r_dir;
   assign w_xfer_in_range = ({1'b0, w_xfer_addr} < c_depth);
   assign w_lat_in_range  = ({1'b0, r_addr} < c_depth);
   assign w_commit        = (r_state == S_RESP) && w_access && r_dir && w_lat_in_range;
   assign w_enter_resp    = (w_next == S_RESP);

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE: begin
            if (w_access) w_next = (c_ws != 4'd0) ? S_WAIT : S_RESP;
         end
         S_WAIT: begin
            if (!w_access)          w_next = S_IDLE;
            else if (r_cnt <= 4'd1) w_next = S_RESP;
            else                    w_next = S_WAIT;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_APB or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_dir   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_access) begin
            r_addr  <= PADDR;
            r_wdata <= PWDATA;
            r_dir   <= PW;
            r_cnt   <= c_ws;
         end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   always_ff @(posedge clk_APB or negedge rst) begin
      if (!rst) begin
         r_pready  <= 1'b0;
         r_prdata  <= '0;
         r_pslverr <= 1'b0;
      end else begin
         r_pready  <= w_enter_resp;
         r_pslverr <= w_enter_resp && !w_xfer_in_range;
         r_prdata  <= (w_enter_resp && !w_xfer_dir && w_xfer_in_range)
                      ? r_mem[w_xfer_addr[c_iw-1:0]] : '0;
      end
   end

   always_ff @(posedge clk_APB or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_commit) begin
         r_mem[r_addr[c_iw-1:0]] <= r_wdata;
      end
   end

   assign PREADY  = r_pready;
   assign PRDATA  = r_prdata;
   assign PSLVERR = r_pslverr;
   assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave
// Purpose  : Directed self-checking bench for apb_slave at 1, 0 and 3 waits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave;

   logic          clk_APB = 1'b0;
   logic          rst;
   logic [2:0]    psel;
   logic          pen;
   logic          pw;
   logic [7:0]    paddr;
   logic [31:0]   pwdata;
   logic          pready  [3];
   logic [31:0]   prdata  [3];
   logic          pslverr [3];
   logic [1:0]    st      [3];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk_APB = ~clk_APB;

   apb_slave #(.size(32), .addr(8), .DEPTH(16), .WAIT_STATES(1)) u_ws1 (
      .clk_APB(clk_APB), .rst(rst), .PSEL(psel[0]), .PEN(pen), .PW(pw),
      .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[0]), .PRDATA(prdata[0]),
      .PSLVERR(pslverr[0]), .state(st[0]));

   apb_slave #(.size(32), .addr(8), .DEPTH(16), .WAIT_STATES(0)) u_ws0 (
      .clk_APB(clk_APB), .rst(rst), .PSEL(psel[1]), .PEN(pen), .PW(pw),
      .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[1]), .PRDATA(prdata[1]),
      .PSLVERR(pslverr[1]), .state(st[1]));

   apb_slave #(.size(32), .addr(8), .DEPTH(16), .WAIT_STATES(3)) u_ws3 (
      .clk_APB(clk_APB), .rst(rst), .PSEL(psel[2]), .PEN(pen), .PW(pw),
      .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[2]), .PRDATA(prdata[2]),
      .PSLVERR(pslverr[2]), .state(st[2]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; leaves the bus idle at a negedge so calls chain
   // back-to-back. scr garbles PADDR/PWDATA once the access phase is running.
   task automatic xfer(input int di, input bit wr, input logic [7:0] a,
                       input logic [31:0] d, input int ws, input bit scr,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input string tag);
      int cyc;
      psel     = 3'b000;
      psel[di] = 1'b1;
      pen      = 1'b0;
      pw       = wr;
      paddr    = a;
      pwdata   = d;
      @(negedge clk_APB);
      check({tag, "_setup"}, 32'(st[di]), 32'd0);
      pen = 1'b1;
      cyc = 1;
      while (pready[di] !== 1'b1 && cyc < 40) begin
         @(negedge clk_APB);
         cyc++;
         if (scr && pready[di] !== 1'b1) begin
            paddr  = a ^ 8'h0B;
            pwdata = ~d;
         end
      end
      check({tag, "_lat"},   32'(cyc), 32'(ws + 2));
      check({tag, "_err"},   32'(pslverr[di]), 32'(exp_err));
      check({tag, "_rdata"}, prdata[di], exp_rd);
      @(negedge clk_APB);
      psel = 3'b000;
      pen  = 1'b0;
      check({tag, "_done"},  32'(pready[di]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst    = 1'b0;
      psel   = 3'b000;
      pen    = 1'b0;
      pw     = 1'b0;
      paddr  = '0;
      pwdata = '0;
      repeat (2) @(negedge clk_APB);
      for (int i = 0; i < 3; i++) begin
         check("rst_state",   32'(st[i]),      32'd0);
         check("rst_pready",  32'(pready[i]),  32'd0);
         check("rst_prdata",  prdata[i],       32'd0);
         check("rst_pslverr", 32'(pslverr[i]), 32'd0);
      end
      rst = 1'b1;
      @(negedge clk_APB);

      // one wait state
      xfer(0, 1'b1, 8'd3, 32'hDEADBEEF, 1, 1'b0, 32'h0,        1'b0, "ws1_w3");
      xfer(0, 1'b0, 8'd3, 32'h0,        1, 1'b0, 32'hDEADBEEF, 1'b0, "ws1_r3");

      // zero wait states, back-to-back
      xfer(1, 1'b1, 8'd0,  32'h1,        0, 1'b0, 32'h0,        1'b0, "ws0_w0");
      xfer(1, 1'b1, 8'd15, 32'hA5A5A5A5, 0, 1'b0, 32'h0,        1'b0, "ws0_w15");
      xfer(1, 1'b0, 8'd15, 32'h0,        0, 1'b0, 32'hA5A5A5A5, 1'b0, "ws0_r15");
      xfer(1, 1'b0, 8'd0,  32'h0,        0, 1'b0, 32'h1,        1'b0, "ws0_r0");

      // out of range
      xfer(1, 1'b0, 8'd20, 32'h0,  0, 1'b0, 32'h0,        1'b1, "oor_r20");
      xfer(1, 1'b1, 8'd20, 32'h55, 0, 1'b0, 32'h0,        1'b1, "oor_w20");
      xfer(1, 1'b0, 8'd4,  32'h0,  0, 1'b0, 32'h0,        1'b0, "oor_r4");
      xfer(1, 1'b0, 8'd0,  32'h0,  0, 1'b0, 32'h1,        1'b0, "oor_r0");
      xfer(1, 1'b0, 8'd15, 32'h0,  0, 1'b0, 32'hA5A5A5A5, 1'b0, "oor_r15");

      // abort: PEN dropped during WAIT
      psel   = 3'b100;
      pen    = 1'b0;
      pw     = 1'b1;
      paddr  = 8'd5;
      pwdata = 32'h1234;
      @(negedge clk_APB);
      pen = 1'b1;
      @(negedge clk_APB);
      check("abort_wait", 32'(st[2]), 32'd1);
      pen = 1'b0;
      @(negedge clk_APB);
      check("abort_idle", 32'(st[2]), 32'd0);
      psel = 3'b000;
      for (int i = 0; i < 4; i++) begin
         check("abort_pready", 32'(pready[2]), 32'd0);
         @(negedge clk_APB);
      end
      xfer(2, 1'b0, 8'd5, 32'h0, 3, 1'b0, 32'h0, 1'b0, "abort_r5");

      // bus garbled during WAIT must not affect the latched transfer
      xfer(2, 1'b1, 8'd2, 32'h77, 3, 1'b1, 32'h0,  1'b0, "scr_w2");
      xfer(2, 1'b0, 8'd2, 32'h0,  3, 1'b0, 32'h77, 1'b0, "scr_r2");
      xfer(2, 1'b0, 8'd9, 32'h0,  3, 1'b0, 32'h0,  1'b0, "scr_r9");

      // reset mid-transfer
      xfer(0, 1'b1, 8'd7, 32'hCAFE, 1, 1'b0, 32'h0,    1'b0, "rst_w7");
      xfer(0, 1'b0, 8'd7, 32'h0,    1, 1'b0, 32'hCAFE, 1'b0, "rst_r7a");
      psel   = 3'b001;
      pen    = 1'b0;
      pw     = 1'b1;
      paddr  = 8'd7;
      pwdata = 32'h1111;
      @(negedge clk_APB);
      pen = 1'b1;
      @(negedge clk_APB);
      check("mid_wait", 32'(st[0]), 32'd1);
      rst = 1'b0;
      #1;
      check("mid_state",   32'(st[0]),      32'd0);
      check("mid_pready",  32'(pready[0]),  32'd0);
      check("mid_prdata",  prdata[0],       32'd0);
      check("mid_pslverr", 32'(pslverr[0]), 32'd0);
      @(negedge clk_APB);
      psel = 3'b000;
      pen  = 1'b0;
      rst  = 1'b1;
      @(negedge clk_APB);
      xfer(0, 1'b0, 8'd7, 32'h0, 1, 1'b0, 32'h0,        1'b0, "rst_r7b");
      xfer(0, 1'b0, 8'd3, 32'h0, 1, 1'b0, 32'h0,        1'b0, "rst_r3");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
